// File: rtl/neopixel_frame_sequencer_if.sv
// Host-write and strand-controller handshake bundle for neopixel_frame_sequencer.
// Signal prefixes are from the sequencer's point of view.
interface neopixel_frame_sequencer_if;
  logic       i_enable;
  logic       i_wr_en;
  logic [2:0] i_wr_pixel;
  logic [1:0] i_wr_color;
  logic [7:0] i_wr_level;
  logic       i_commit;
  logic       i_ready_to_load;
  logic       i_ready_to_send;
  logic [2:0] o_pixel_index;
  logic [1:0] o_color_index;
  logic [7:0] o_color_level;
  logic       o_load_color;
  logic       o_send_it;
  logic       o_busy;
  logic       o_frame_overrun;
  logic [15:0] o_frame_count;

  modport slave (
    input  i_enable, i_wr_en, i_wr_pixel, i_wr_color, i_wr_level, i_commit,
           i_ready_to_load, i_ready_to_send,
    output o_pixel_index, o_color_index, o_color_level, o_load_color,
           o_send_it, o_busy, o_frame_overrun, o_frame_count
  );

  modport master (
    output i_enable, i_wr_en, i_wr_pixel, i_wr_color, i_wr_level, i_commit,
           i_ready_to_load, i_ready_to_send,
    input  o_pixel_index, o_color_index, o_color_level, o_load_color,
           o_send_it, o_busy, o_frame_overrun, o_frame_count
  );
endinterface

// File: rtl/neopixel_frame_sequencer.sv
// Double-buffered GRB frame store that replays the active frame into the strand
// controller's byte-load handshake on every refresh tick, then requests a send.
module neopixel_frame_sequencer #(
  parameter int NUM_PIXELS   = 5,
  parameter int FRAME_PERIOD = 750000
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  neopixel_frame_sequencer_if.slave  bus
);

  localparam int              TW         = $clog2(FRAME_PERIOD);
  localparam logic [TW-1:0]   LP_TMAX    = TW'(FRAME_PERIOD - 1);
  localparam logic [2:0]      LP_LASTPIX = 3'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_pixel;
  logic [1:0]    r_color;
  logic          r_pending;
  logic [15:0]   r_frame_count;
  logic [7:0]    r_stage  [NUM_PIXELS][3];
  logic [7:0]    r_active [NUM_PIXELS][3];

  logic w_tick;
  logic w_start;
  logic w_load;
  logic w_send;
  logic w_last;
  logic w_wr_ok;

  assign w_tick  = (r_timer == LP_TMAX);
  assign w_last  = (r_pixel == LP_LASTPIX) && (r_color == 2'd2);
  assign w_wr_ok = bus.i_wr_en && ({1'b0, bus.i_wr_pixel} < 4'(NUM_PIXELS))
                   && (bus.i_wr_color != 2'd3);

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_load      = 1'b0;
    w_send      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tick && bus.i_enable) begin
          w_state_nxt = S_LOAD;
          w_start     = 1'b1;
        end
      end
      S_LOAD: begin
        w_load = bus.i_ready_to_load;
        if (w_load && w_last) w_state_nxt = S_SEND;
      end
      S_SEND: begin
        w_send = bus.i_ready_to_send;
        if (w_send) w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: if (!bus.i_ready_to_load) w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (bus.i_ready_to_load)  w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Control: FSM, refresh timer, byte counters, commit flag and frame counter
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_pixel       <= 3'd0;
      r_color       <= 2'd0;
      r_pending     <= 1'b0;
      r_frame_count <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_tick ? '0 : r_timer + 1'b1;
      if (w_start) begin
        r_pixel <= 3'd0;
        r_color <= 2'd0;
      end else if (w_load) begin
        if (r_color == 2'd2) begin
          r_color <= 2'd0;
          // wrap to 0/0 after the final byte so IDLE presents pixel 0 green
          r_pixel <= w_last ? 3'd0 : r_pixel + 3'd1;
        end else begin
          r_color <= r_color + 2'd1;
        end
      end
      // a commit coinciding with the frame-start copy is held for the next frame
      if (w_start)            r_pending <= bus.i_commit;
      else if (bus.i_commit)  r_pending <= 1'b1;
      if (w_send) r_frame_count <= r_frame_count + 16'd1;
    end
  end

  // Frame buffers: copy reads the pre-edge staging contents
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int p = 0; p < NUM_PIXELS; p++) begin
        for (int c = 0; c < 3; c++) begin
          r_stage[p][c]  <= 8'd0;
          r_active[p][c] <= 8'd0;
        end
      end
    end else begin
      if (w_wr_ok) r_stage[bus.i_wr_pixel][bus.i_wr_color] <= bus.i_wr_level;
      if (w_start && r_pending) r_active <= r_stage;
    end
  end

  assign bus.o_pixel_index   = r_pixel;
  assign bus.o_color_index   = r_color;
  assign bus.o_color_level   = r_active[r_pixel][r_color];
  assign bus.o_load_color    = w_load;
  assign bus.o_send_it       = w_send;
  assign bus.o_busy          = (r_state != S_IDLE);
  assign bus.o_frame_overrun = w_tick && (r_state != S_IDLE);
  assign bus.o_frame_count   = r_frame_count;

endmodule
